// File: rtl/sprite_bounce_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_bounce_engine
//  Description : Animates NUM_OBJ square sprites bouncing inside the frame,
//                streaming draw/erase pixel writes to a frame buffer.
//                Optional full-screen clear after reset: SPRITE_SCREEN_CLEAR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_bounce_engine #(
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int BOX         = 4,
    parameter int NUM_OBJ     = 2,
    parameter int FRAME_TICKS = 12500000,
    parameter int X_W         = 8,
    parameter int Y_W         = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3*NUM_OBJ-1:0] obj_colour,
    input  logic                 pause,
    output logic [X_W-1:0]       x,
    output logic [Y_W-1:0]       y,
    output logic [2:0]           colour,
    output logic                 plot,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int c_obj_w = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam int c_box_w = $clog2(BOX);
    localparam int c_tmr_w = $clog2(FRAME_TICKS + 1);

    localparam logic [c_obj_w-1:0] c_obj_last = c_obj_w'(NUM_OBJ - 1);
    localparam logic [c_box_w-1:0] c_box_last = c_box_w'(BOX - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(FRAME_TICKS - 1);
    localparam logic [X_W-1:0]     c_max_x    = X_W'(SCREEN_W - BOX);
    localparam logic [Y_W-1:0]     c_max_y    = Y_W'(SCREEN_H - BOX);
    localparam logic [X_W-1:0]     c_one_x    = X_W'(1);
    localparam logic [Y_W-1:0]     c_one_y    = Y_W'(1);

    localparam logic [2:0] c_st_init  = 3'd1;
    localparam logic [2:0] c_st_draw  = 3'd2;
    localparam logic [2:0] c_st_wait  = 3'd3;
    localparam logic [2:0] c_st_erase = 3'd4;
    localparam logic [2:0] c_st_move  = 3'd5;
`ifdef SPRITE_SCREEN_CLEAR_EN
    localparam logic [2:0] c_st_clear = 3'd0;
    localparam logic [2:0] c_st_reset = c_st_clear;
`else
    localparam logic [2:0] c_st_reset = c_st_init;
`endif

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;

    logic [c_obj_w-1:0] r_obj;
    logic [c_box_w-1:0] r_col;
    logic [c_box_w-1:0] r_row;
    logic [c_tmr_w-1:0] r_tmr;

    logic [X_W-1:0]     r_pos_x [NUM_OBJ];
    logic [Y_W-1:0]     r_pos_y [NUM_OBJ];
    logic [NUM_OBJ-1:0] r_dir_x;
    logic [NUM_OBJ-1:0] r_dir_y;
    logic [NUM_OBJ-1:0] w_dx_neg;
    logic [NUM_OBJ-1:0] w_dy_neg;

    logic               w_pix_en;
    logic               w_erase;
    logic               w_clr_en;
    logic               w_load;
    logic               w_move;
    logic               w_wait;
    logic               w_box_last;
    logic               w_phase_last;
    logic               w_tmr_done;
    logic               w_clr_last;
    logic [X_W-1:0]     w_cur_x;
    logic [Y_W-1:0]     w_cur_y;
    logic [2:0]         w_cur_colour;

    assign w_box_last   = (r_col == c_box_last) && (r_row == c_box_last);
    assign w_phase_last = w_box_last && (r_obj == c_obj_last);
    assign w_tmr_done   = !pause && (r_tmr == c_tmr_last);

    // ------------------------------------------------------------------
    // FSM: state register / next state / output decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_reset;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
`ifdef SPRITE_SCREEN_CLEAR_EN
            c_st_clear: if (w_clr_last) w_next_state = c_st_init;
`endif
            c_st_init:  w_next_state = c_st_draw;
            c_st_draw:  if (w_phase_last) w_next_state = c_st_wait;
            c_st_wait:  if (w_tmr_done) w_next_state = c_st_erase;
            c_st_erase: if (w_phase_last) w_next_state = c_st_move;
            c_st_move:  w_next_state = c_st_draw;
            default:    w_next_state = c_st_reset;
        endcase
    end

    always_comb begin
        w_pix_en = 1'b0;
        w_erase  = 1'b0;
        w_clr_en = 1'b0;
        w_load   = 1'b0;
        w_move   = 1'b0;
        w_wait   = 1'b0;
        case (r_state)
`ifdef SPRITE_SCREEN_CLEAR_EN
            c_st_clear: w_clr_en = 1'b1;
`endif
            c_st_init:  w_load   = 1'b1;
            c_st_draw:  w_pix_en = 1'b1;
            c_st_wait:  w_wait   = 1'b1;
            c_st_erase: begin
                w_pix_en = 1'b1;
                w_erase  = 1'b1;
            end
            c_st_move:  w_move   = 1'b1;
            default:    w_wait   = 1'b0;
        endcase
    end

    assign busy = !w_wait;

    // ------------------------------------------------------------------
    // Sprite pixel walk (column fastest, sprite 0 first) and frame timer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_obj <= '0;
            r_col <= '0;
            r_row <= '0;
            r_tmr <= '0;
        end else begin
            if (w_pix_en) begin
                if (r_col == c_box_last) begin
                    r_col <= '0;
                    if (r_row == c_box_last) begin
                        r_row <= '0;
                        r_obj <= (r_obj == c_obj_last) ? '0 : r_obj + 1'b1;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_wait && !pause) begin
                r_tmr <= w_tmr_done ? '0 : r_tmr + 1'b1;
            end
        end
    end

`ifdef SPRITE_SCREEN_CLEAR_EN
    localparam logic [X_W-1:0] c_scr_x_last = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] c_scr_y_last = Y_W'(SCREEN_H - 1);

    logic [X_W-1:0] r_clr_x;
    logic [Y_W-1:0] r_clr_y;

    assign w_clr_last = (r_clr_x == c_scr_x_last) && (r_clr_y == c_scr_y_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_x <= '0;
            r_clr_y <= '0;
        end else if (w_clr_en) begin
            if (r_clr_x == c_scr_x_last) begin
                r_clr_x <= '0;
                r_clr_y <= (r_clr_y == c_scr_y_last) ? '0 : r_clr_y + c_one_y;
            end else begin
                r_clr_x <= r_clr_x + c_one_x;
            end
        end
    end
`else
    assign w_clr_last = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Per-sprite motion: bounce off an edge, then step, in one cycle
    // ------------------------------------------------------------------
    always_comb begin
        w_dx_neg = r_dir_x;
        w_dy_neg = r_dir_y;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (r_pos_x[i] == '0)          w_dx_neg[i] = 1'b0;
            else if (r_pos_x[i] == c_max_x) w_dx_neg[i] = 1'b1;
            if (r_pos_y[i] == '0)          w_dy_neg[i] = 1'b0;
            else if (r_pos_y[i] == c_max_y) w_dy_neg[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_load) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_pos_x[i] <= X_W'(i * 2 * BOX);
                r_pos_y[i] <= '0;
                r_dir_x[i] <= ((i % 2) == 1);
                r_dir_y[i] <= 1'b0;
            end
        end else if (w_move) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_dir_x[i] <= w_dx_neg[i];
                r_dir_y[i] <= w_dy_neg[i];
                r_pos_x[i] <= w_dx_neg[i] ? r_pos_x[i] - c_one_x : r_pos_x[i] + c_one_x;
                r_pos_y[i] <= w_dy_neg[i] ? r_pos_y[i] - c_one_y : r_pos_y[i] + c_one_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered pixel port; lags the walk counters by one cycle
    // ------------------------------------------------------------------
    assign w_cur_x      = r_pos_x[r_obj] + X_W'(r_col);
    assign w_cur_y      = r_pos_y[r_obj] + Y_W'(r_row);
    assign w_cur_colour = obj_colour[3*r_obj +: 3];

    always_ff @(posedge clk) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_move;
            plot       <= w_pix_en | w_clr_en;
            if (w_pix_en) begin
                x      <= w_cur_x;
                y      <= w_cur_y;
                colour <= w_erase ? 3'd0 : w_cur_colour;
            end
`ifdef SPRITE_SCREEN_CLEAR_EN
            else if (w_clr_en) begin
                x      <= r_clr_x;
                y      <= r_clr_y;
                colour <= 3'd0;
            end
`endif
        end
    end

endmodule
`default_nettype wire
